// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM: drives ALU op, operand selects
// and datapath strobes one state per cycle (3-5 cycles/instr).
// Ports: clk, reset (sync, active-high); op, funct3, funct7_b5,
// zero in; alu_op, alu_src_a/b, result_src, adr_src, ir_write,
// pc_write, reg_write, mem_write, instr_done, illegal, state out.
module multicycle_control_unit #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  input  logic       zero,
  output logic [3:0] alu_op,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_JALR     = 4'd11;
  localparam logic [3:0] S_JALRLINK = 4'd12;
  localparam logic [3:0] S_LUI      = 4'd13;
  localparam logic [3:0] S_ILLEGAL  = 4'd14;

  localparam logic [3:0] A_ADD  = 4'b0010;
  localparam logic [3:0] A_SUB  = 4'b0110;
  localparam logic [3:0] A_AND  = 4'b0000;
  localparam logic [3:0] A_OR   = 4'b0001;
  localparam logic [3:0] A_XOR  = 4'b1010;
  localparam logic [3:0] A_SLL  = 4'b1000;
  localparam logic [3:0] A_SRL  = 4'b1001;
  localparam logic [3:0] A_SLT  = 4'b0111;
  localparam logic [3:0] A_SLTU = 4'b1111;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic [3:0] cur;

  logic is_load;
  logic is_store;
  logic is_r;
  logic is_i;
  logic is_br;
  logic is_jal;
  logic is_jalr;
  logic is_lui;
  logic is_auipc;
  logic word_ok;
  logic sra_bad;
  logic br_bad;
  logic taken;
  logic [3:0] br_op;

  function automatic logic [3:0] alu_map(
    input logic [2:0] f3,
    input logic       sub
  );
    logic [3:0] r;
    case (f3)
      3'b000:  r = sub ? A_SUB : A_ADD;
      3'b001:  r = A_SLL;
      3'b010:  r = A_SLT;
      3'b011:  r = A_SLTU;
      3'b100:  r = A_XOR;
      3'b101:  r = A_SRL;
      3'b110:  r = A_OR;
      default: r = A_AND;
    endcase
    return r;
  endfunction

  assign is_load  = (op == OP_LOAD);
  assign is_store = (op == OP_STORE);
  assign is_r     = (op == OP_R);
  assign is_i     = (op == OP_I);
  assign is_br    = (op == OP_BR);
  assign is_jal   = (op == OP_JAL);
  assign is_jalr  = (op == OP_JALR);
  assign is_lui   = (op == OP_LUI);
  assign is_auipc = (op == OP_AUIPC);
  assign word_ok  = (funct3 == 3'b010);
  // No arithmetic shifter in the ALU, so SRA/SRAI are rejected.
  assign sra_bad  = (funct3 == 3'b101) && funct7_b5;
  assign br_bad   = (funct3[2:1] == 2'b01);

  // SLT/SLTU leave zero=1 when the compare is false, so the
  // "less than" branches take on !zero and the "ge" ones on zero.
  always_comb begin
    taken = 1'b0;
    br_op = A_ADD;
    case (funct3)
      3'b000: begin taken = zero;  br_op = A_SUB;  end
      3'b001: begin taken = !zero; br_op = A_SUB;  end
      3'b100: begin taken = !zero; br_op = A_SLT;  end
      3'b101: begin taken = zero;  br_op = A_SLT;  end
      3'b110: begin taken = !zero; br_op = A_SLTU; end
      3'b111: begin taken = zero;  br_op = A_SLTU; end
      default: begin taken = 1'b0; br_op = A_ADD; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= RESET_STATE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        state_d = S_ILLEGAL;
        unique case (1'b1)
          is_load, is_store:
            state_d = word_ok ? S_MEMADR : S_ILLEGAL;
          is_r:     state_d = sra_bad ? S_ILLEGAL : S_EXECR;
          is_i:     state_d = sra_bad ? S_ILLEGAL : S_EXECI;
          is_br:    state_d = br_bad ? S_ILLEGAL : S_BRANCH;
          is_jal:   state_d = S_JAL;
          is_jalr:  state_d = S_JALR;
          is_lui:   state_d = S_LUI;
          is_auipc: state_d = S_ALUWB;
          default:  state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = is_load ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_JALR:     state_d = S_JALRLINK;
      S_JALRLINK: state_d = S_ALUWB;
      S_LUI:      state_d = S_ALUWB;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_FETCH;
    endcase
  end

  // While reset is high the selects show FETCH values and every
  // strobe is forced low, whatever state the register still holds.
  assign cur   = reset ? S_FETCH : state_q;
  assign state = state_q;

  always_comb begin
    alu_op     = A_ADD;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (cur)
      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_write   = 1'b1;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = alu_map(funct3, funct7_b5);
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = alu_map(funct3, 1'b0);
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_op     = br_op;
        pc_write   = taken;
        instr_done = 1'b1;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      S_JALR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = 1'b1;
      end
      S_JALRLINK: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
      end
      S_ILLEGAL: illegal = 1'b1;
      default: ;
    endcase
    if (reset) begin
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule
